// File: rtl/mult32x32_pkg.sv
// -----------------------------------------------------------------------------
// mult32x32_pkg
// Shared definitions for the two-requester 32x32 multiplier arbiter.
//   state_t    : arbiter FSM states (IDLE, START, WAIT, DONE)
//   OPERAND_W  : operand width
//   PRODUCT_W  : product width
//   NUM_REQ    : number of requesters
//   onehot_of  : requester index -> one-hot request/grant vector
// -----------------------------------------------------------------------------
package mult32x32_pkg;

    localparam int OPERAND_W = 32;
    localparam int PRODUCT_W = 64;
    localparam int NUM_REQ   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot_of(input logic idx);
        onehot_of = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mult32x32_arbiter_arb2_rr.sv
// -----------------------------------------------------------------------------
// arb2_rr
// Two-way request arbiter. Picks the winning requester index from the request
// vector. With MULT32X32_ARB_RR_EN defined a pointer register remembers which
// requester is preferred on the next tie (round-robin); otherwise requester 0
// always wins ties and no pointer register exists.
// Ports:
//   clk, reset  : clock / async active-low reset (round-robin build only)
//   i_advance   : a grant is being taken this cycle (round-robin build only)
//   i_req       : request vector
//   o_winner    : index of the winning requester (meaningful when i_req != 0)
// Configuration macro: MULT32X32_ARB_RR_EN
// -----------------------------------------------------------------------------
module arb2_rr
    import mult32x32_pkg::*;
(
`ifdef MULT32X32_ARB_RR_EN
    input  logic               clk,
    input  logic               reset,
    input  logic               i_advance,
`endif
    input  logic [NUM_REQ-1:0] i_req,
    output logic               o_winner
);

`ifdef MULT32X32_ARB_RR_EN
    logic r_ptr;

    // Preferred requester for the next tie: the one not just granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~o_winner;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Winner selection: pointer breaks a tie, a lone request wins outright.
    always_comb begin
        o_winner = 1'b0;
        if (i_req == 2'b11) begin
            o_winner = r_ptr;
        end else begin
            o_winner = i_req[1];
        end
    end
`else
    // Winner selection: requester 1 wins only when requester 0 is absent.
    always_comb begin
        o_winner = 1'b0;
        if (i_req[0]) begin
            o_winner = 1'b0;
        end else begin
            o_winner = i_req[1];
        end
    end
`endif

endmodule

// File: rtl/mult32x32_arbiter.sv
// -----------------------------------------------------------------------------
// mult32x32_arbiter
// Shares one external 32x32 multiplier between two requesters.
// Flow: IDLE captures the winner's operands -> START pulses mult_start/gnt ->
// WAIT until the multiplier's busy has risen and fallen -> DONE pulses done
// with the product. A watchdog aborts WAIT after MAX_WAIT cycles, setting the
// sticky err flag and completing with product 0.
// Parameters:
//   MAX_WAIT     : cycles allowed in WAIT before abort (legal 2..255)
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   req[1:0]     : requests (held with operands until gnt)
//   a0,b0,a1,b1  : unsigned operands of requester 0 / 1
//   gnt[1:0]     : one-cycle operand-capture pulse for the winner
//   done[1:0]    : one-cycle result-valid pulse for the winner
//   product      : result while a done bit is high, else 0
//   err          : sticky watchdog flag
//   mult_start, mult_a, mult_b : multiplier command
//   mult_busy, mult_product    : multiplier status / result
// Configuration macro: MULT32X32_ARB_RR_EN (round-robin tie-break when defined,
// fixed priority to requester 0 otherwise).
// -----------------------------------------------------------------------------
module mult32x32_arbiter
    import mult32x32_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [OPERAND_W-1:0] a0,
    input  logic [OPERAND_W-1:0] b0,
    input  logic [OPERAND_W-1:0] a1,
    input  logic [OPERAND_W-1:0] b1,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [PRODUCT_W-1:0] product,
    output logic                 err,
    output logic                 mult_start,
    output logic [OPERAND_W-1:0] mult_a,
    output logic [OPERAND_W-1:0] mult_b,
    input  logic                 mult_busy,
    input  logic [PRODUCT_W-1:0] mult_product
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_winner;
    logic                   w_winner;
    logic                   w_capture;
    logic [7:0]             r_wait_cnt;
    logic                   r_seen_busy;
    logic [NUM_REQ-1:0]     r_gnt;
    logic [NUM_REQ-1:0]     w_gnt_nxt;
    logic [NUM_REQ-1:0]     r_done;
    logic [NUM_REQ-1:0]     w_done_nxt;
    logic [PRODUCT_W-1:0]   r_product;
    logic [PRODUCT_W-1:0]   w_product_nxt;
    logic                   r_err;
    logic                   w_err_nxt;
    logic                   r_mult_start;
    logic                   w_start_nxt;
    logic [OPERAND_W-1:0]   r_mult_a;
    logic [OPERAND_W-1:0]   r_mult_b;

    arb2_rr u_arb (
`ifdef MULT32X32_ARB_RR_EN
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_capture),
`endif
        .i_req     (req),
        .o_winner  (w_winner)
    );

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = 2'b00;
        w_done_nxt    = 2'b00;
        w_product_nxt = 64'd0;
        w_err_nxt     = r_err;
        w_start_nxt   = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_capture   = 1'b1;
                    w_start_nxt = 1'b1;
                    w_gnt_nxt   = onehot_of(w_winner);
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // Completion needs a busy high seen first, so a late-rising
                // busy is not mistaken for an already finished multiply.
                if (r_seen_busy && !mult_busy) begin
                    w_state_nxt   = DONE;
                    w_done_nxt    = onehot_of(r_winner);
                    w_product_nxt = mult_product;
                end else if (r_wait_cnt == 8'(MAX_WAIT - 1)) begin
                    w_state_nxt   = DONE;
                    w_done_nxt    = onehot_of(r_winner);
                    w_product_nxt = 64'd0;
                    w_err_nxt     = 1'b1;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register, registered outputs and operand capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_winner     <= 1'b0;
            r_gnt        <= 2'b00;
            r_done       <= 2'b00;
            r_product    <= 64'd0;
            r_err        <= 1'b0;
            r_mult_start <= 1'b0;
            r_mult_a     <= 32'd0;
            r_mult_b     <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_done       <= w_done_nxt;
            r_product    <= w_product_nxt;
            r_err        <= w_err_nxt;
            r_mult_start <= w_start_nxt;
            if (w_capture) begin
                r_winner <= w_winner;
                r_mult_a <= w_winner ? a1 : a0;
                r_mult_b <= w_winner ? b1 : b0;
            end else begin
                r_winner <= r_winner;
                r_mult_a <= r_mult_a;
                r_mult_b <= r_mult_b;
            end
        end
    end

    // Cycles spent in WAIT and whether busy has been observed high there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt  <= 8'd0;
            r_seen_busy <= 1'b0;
        end else if (r_state == WAIT) begin
            r_wait_cnt  <= r_wait_cnt + 8'd1;
            r_seen_busy <= r_seen_busy | mult_busy;
        end else begin
            r_wait_cnt  <= 8'd0;
            r_seen_busy <= 1'b0;
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign product    = r_product;
    assign err        = r_err;
    assign mult_start = r_mult_start;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult32x32_arbiter
// Self-checking bench for mult32x32_arbiter. Contains a behavioural multiplier
// (busy for a programmable number of cycles, optionally stuck), a transaction
// level model of the arbitration policy, a directed vector table, hand-written
// corner sequences and a randomized phase. Honours MULT32X32_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_mult32x32_arbiter;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  gnt, done;
    logic [63:0] product;
    logic        err, mult_start;
    logic [31:0] mult_a, mult_b;
    logic        mult_busy;
    logic [63:0] mult_product;

    int checks = 0;
    int failures = 0;

    mult32x32_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .done(done), .product(product), .err(err),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_busy(mult_busy), .mult_product(mult_product)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: busy for busy_len cycles after a start.
    int          busy_len = 1;
    bit          stuck = 1'b0;
    int          m_cnt;
    logic [63:0] m_prod;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt  <= 0;
            m_prod <= 64'd0;
        end else if (mult_start) begin
            m_cnt  <= busy_len;
            m_prod <= 64'(mult_a) * 64'(mult_b);
        end else if (m_cnt != 0 && !stuck) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign mult_busy    = (m_cnt != 0);
    assign mult_product = m_prod;

    // Invariant monitor and pulse counters.
    int viol = 0, n_gnt = 0, n_start = 0, n_done = 0;
    always @(negedge clk) begin
        if (reset) begin
            if ($countones(gnt) > 1 || $countones(done) > 1) viol++;
            if (done == 2'b00 && product != 64'd0) viol++;
            if (gnt != 2'b00) n_gnt++;
            if (mult_start) n_start++;
            if (done != 2'b00) n_done++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference policy: lone request wins; a tie goes to the preferred one.
    int pref = 0;
    function automatic int model_pick(input logic [1:0] pend);
        if (pend == 2'b01) return 0;
        if (pend == 2'b10) return 1;
        return pref;
    endfunction

    task automatic model_granted(input int w);
`ifdef MULT32X32_ARB_RR_EN
        pref = 1 - w;
`else
        pref = 0;
`endif
    endtask

    // Wait for a grant to requester w and its done; check everything on the way.
    task automatic serve_one(input int w, input logic [63:0] exp_prod, input bit drop, input int exp_lat);
        int n;
        logic [31:0] ea, eb;
        ea = (w == 1) ? a1 : a0;
        eb = (w == 1) ? b1 : b0;
        n = 0;
        while (gnt == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (gnt == 2'b00) begin
            failures++;
            $display("FAIL gnt_timeout: got no grant expected grant to %0d", w);
            return;
        end
        chk("gnt", 64'(gnt), (w == 1) ? 64'd2 : 64'd1);
        chk("start_with_gnt", 64'(mult_start), 64'd1);
        model_granted(w);
        if (drop) req[w] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 2'b00 && n < 300);
        checks++;
        if (done == 2'b00) begin
            failures++;
            $display("FAIL done_timeout: got no done expected done for %0d", w);
            return;
        end
        chk("done", 64'(done), (w == 1) ? 64'd2 : 64'd1);
        chk("product", product, exp_prod);
        chk("mult_a_stable", 64'(mult_a), 64'(ea));
        chk("mult_b_stable", 64'(mult_b), 64'(eb));
        if (exp_lat > 0) chk("latency", 64'(n), 64'(exp_lat));
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0, b0, a1, b1;
        int          busy;
        int          first;
        logic [63:0] p_first;
        logic [63:0] p_second;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int s0, g0, d0, w;
        logic [1:0] pend;

        tbl[0] = '{2'b01, 32'd3, 32'd5, 32'd0, 32'd0, 4, 0, 64'd15, 64'd0};
        tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 2, 0, 64'hFFFFFFFE00000001, 64'd0};
        tbl[2] = '{2'b10, 32'd0, 32'd0, 32'd7, 32'd6, 3, 1, 64'd42, 64'd0};
        tbl[3] = '{2'b11, 32'd2, 32'd2, 32'd7, 32'd6, 4, 0, 64'd4, 64'd42};
        tbl[4] = '{2'b01, 32'd9, 32'd9, 32'd0, 32'd0, 1, 0, 64'd81, 64'd0};
`ifdef MULT32X32_ARB_RR_EN
        tbl[5] = '{2'b11, 32'd11, 32'd11, 32'd12, 32'd12, 5, 1, 64'd144, 64'd121};
`else
        tbl[5] = '{2'b11, 32'd11, 32'd11, 32'd12, 32'd12, 5, 0, 64'd121, 64'd144};
`endif

        req = 2'b00; a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_start", 64'(mult_start), 64'd0);
        chk("rst_mult_a", 64'(mult_a), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_gnt", 64'(gnt), 64'd0);

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            req = tbl[i].req;
            a0 = tbl[i].a0; b0 = tbl[i].b0; a1 = tbl[i].a1; b1 = tbl[i].b1;
            busy_len = tbl[i].busy;
            s0 = n_start;
            serve_one(tbl[i].first, tbl[i].p_first, 1'b1, tbl[i].busy + 2);
            if (tbl[i].req == 2'b11)
                serve_one(1 - tbl[i].first, tbl[i].p_second, 1'b1, tbl[i].busy + 2);
            chk("start_count", 64'(n_start - s0), (tbl[i].req == 2'b11) ? 64'd2 : 64'd1);
            repeat (2) @(negedge clk);
        end

        // Both requests held continuously across several grants.
        req = 2'b11; a0 = 32'd4; b0 = 32'd4; a1 = 32'd5; b1 = 32'd5; busy_len = 2;
        for (int k = 0; k < 4; k++) begin
            w = model_pick(2'b11);
            serve_one(w, (w == 1) ? 64'd25 : 64'd16, 1'b0, 4);
        end
        req = 2'b00;
        repeat (4) @(negedge clk);

        // Withdraw before grant: request raised and dropped while busy elsewhere.
        req = 2'b01; a0 = 32'd6; b0 = 32'd7; busy_len = 5;
        serve_one(0, 64'd42, 1'b1, 7);
        req[1] = 1'b1; a1 = 32'd3; b1 = 32'd3;
        @(negedge clk);
        req[1] = 1'b0;
        g0 = n_gnt;
        repeat (6) @(negedge clk);
        chk("withdraw_no_gnt", 64'(n_gnt), 64'(g0));

        // Watchdog: busy stuck high.
        req = 2'b01; a0 = 32'd9; b0 = 32'd9; busy_len = 1; stuck = 1'b1;
        serve_one(0, 64'd0, 1'b1, MAX_WAIT + 1);
        chk("wd_err", 64'(err), 64'd1);
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        req = 2'b10; a1 = 32'd3; b1 = 32'd3; busy_len = 2;
        serve_one(1, 64'd9, 1'b1, 4);
        chk("err_sticky", 64'(err), 64'd1);
        repeat (2) @(negedge clk);

        // Reset in the middle of WAIT.
        req = 2'b01; a0 = 32'd100; b0 = 32'd100; busy_len = 8;
        for (int n = 0; n < 30 && gnt == 2'b00; n++) @(negedge clk);
        req = 2'b00;
        repeat (3) @(negedge clk);
        d0 = n_done;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'(gnt), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_product", product, 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_start", 64'(mult_start), 64'd0);
        chk("mid_rst_mult_a", 64'(mult_a), 64'd0);
        chk("mid_rst_mult_b", 64'(mult_b), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        pref = 0;
        repeat (12) @(negedge clk);
        chk("no_done_after_rst", 64'(n_done), 64'(d0));
        req = 2'b10; a1 = 32'd20; b1 = 32'd30; busy_len = 3;
        serve_one(1, 64'd600, 1'b1, 5);
        repeat (2) @(negedge clk);
        req = 2'b11; a0 = 32'd2; b0 = 32'd3; a1 = 32'd4; b1 = 32'd5; busy_len = 2;
        w = model_pick(2'b11);
        serve_one(w, (w == 1) ? 64'd20 : 64'd6, 1'b1, 4);
        serve_one(1 - w, (w == 1) ? 64'd6 : 64'd20, 1'b1, 4);
        repeat (2) @(negedge clk);

        // Randomized transactions against the reference model.
        for (int t = 0; t < 40; t++) begin
            pend = 2'($urandom_range(1, 3));
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF;
            end
            busy_len = $urandom_range(1, 8);
            req = pend;
            while (pend != 2'b00) begin
                w = model_pick(pend);
                serve_one(w, (w == 1) ? 64'(a1) * 64'(b1) : 64'(a0) * 64'(b0), 1'b1, busy_len + 2);
                pend[w] = 1'b0;
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        chk("invariants", 64'(viol), 64'd0);
        chk("start_eq_gnt", 64'(n_start), 64'(n_gnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
